date_keeper: RTL and testbench
==============================

DATE_KEEPER -- requirements
Module: date_keeper

Interface
REQ-001 The block SHALL have the parameter YEAR_W, default 12, meaning the year field width in bits.
REQ-002 The block SHALL have the parameter YEAR_MIN, default 2000, meaning the lowest representable year and the reset year.
REQ-003 The block SHALL have the parameter YEAR_MAX, default 2099, meaning the highest year before wrap to YEAR_MIN.
REQ-004 The block SHALL have the parameter WDAY_INIT, default 6, meaning the weekday at reset (0=Sunday..6=Saturday; 2000-01-01 is Saturday).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port day_tick, input, 1 bit: advance the date by one day.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load request.
REQ-009 The block SHALL have ports ld_day (5), ld_month (4), ld_year (YEAR_W) and ld_wday (3), all inputs: the load values.
REQ-010 The block SHALL have port rd_en, input, 1 bit: read-bus enable.
REQ-011 The block SHALL have outputs day (5), month (4), year (YEAR_W) and wday (3): the registered current date.
REQ-012 The block SHALL have outputs bus_day, bus_month, bus_year and bus_wday, same widths: the current date ANDed with rd_en (all zero when rd_en=0).
REQ-013 The block SHALL have outputs month_end, year_end and load_err, 1 bit each, registered: single-cycle status pulses.

Function
REQ-014 Month length SHALL be 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 of a leap year; 28 otherwise.
REQ-015 A year SHALL be leap when divisible by 4 and (not divisible by 100 or divisible by 400).
REQ-016 On day_tick=1 with load=0: day < month length -> day+1; otherwise day=1 and month+1.
REQ-017 At the month rollover from month=12, month SHALL become 1 and year+1; when year=YEAR_MAX, year SHALL wrap to YEAR_MIN.
REQ-018 Every accepted day_tick SHALL advance wday modulo 7 (6 -> 0), independent of the date fields.
REQ-019 All outputs SHALL update one clock edge after the tick; day_tick held high for N cycles SHALL advance the date N days.
REQ-020 month_end SHALL be 1 for exactly the cycle following the edge at which a tick caused a day rollover to 1; year_end likewise for a month 12 -> 1 rollover.
REQ-021 A load SHALL be valid when 1<=ld_month<=12, 1<=ld_day<=length(ld_month, ld_year), YEAR_MIN<=ld_year<=YEAR_MAX, and ld_wday<=6.
REQ-022 A valid load SHALL replace all four fields at the next edge, with load_err=0, month_end=0 and year_end=0.
REQ-023 An invalid load SHALL leave all fields unchanged and pulse load_err=1 for one cycle.
REQ-024 When load and day_tick are both 1, the load SHALL take priority and the tick SHALL be discarded, even if the load is invalid.
REQ-025 Status pulses SHALL return to 0 in any cycle with no qualifying event.
REQ-026 The bus_* outputs SHALL be combinational in rd_en over the registered fields.

Reset
REQ-027 While rst_n=0, the outputs SHALL be, immediately and without a clock: day=1, month=1, year=YEAR_MIN, wday=WDAY_INIT, month_end=0, year_end=0, load_err=0.
REQ-028 A reset asserted mid-operation SHALL discard any in-flight tick or load.
REQ-029 The first tick or load SHALL be honoured at the first rising edge after rst_n rises.

Verification
REQ-030 The bench SHALL cover reset with rd_en=0 -> day=1, month=1, year=2000, wday=6; all bus_*=0; with rd_en=1, bus_* equal the fields.
REQ-031 The bench SHALL cover: load 2024-02-28 with wday=3, then two ticks -> 2024-02-29 wday=4, then 2024-03-01 wday=5 with month_end=1 for one cycle.
REQ-032 The bench SHALL cover: with YEAR_MAX=2199, load 2100-02-28 and tick -> 2100-03-01; a load of 2000-02-29 is accepted with load_err=0.
REQ-033 The bench SHALL cover: load 2099-12-31 with wday=4, then tick -> 2000-01-01 wday=5, with month_end=1 and year_end=1 in the same cycle.
REQ-034 The bench SHALL cover: load 2023-02-29 together with day_tick=1 -> load_err=1 for one cycle, and date and wday unchanged (tick discarded).
REQ-035 The bench SHALL cover: rst_n low between clock edges after a load of 2050-07-15 -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/date_keeper.sv
// Calendar date keeper: tracks day/month/year/weekday with per-day ticks,
// validated synchronous loads and single-cycle rollover/error status pulses.
module date_keeper #(
    parameter int YEAR_W    = 12,
    parameter int YEAR_MIN  = 2000,
    parameter int YEAR_MAX  = 2099,
    parameter int WDAY_INIT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              day_tick,
    input  logic              load,
    input  logic [4:0]        ld_day,
    input  logic [3:0]        ld_month,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic [2:0]        ld_wday,
    input  logic              rd_en,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        wday,
    output logic [4:0]        bus_day,
    output logic [3:0]        bus_month,
    output logic [YEAR_W-1:0] bus_year,
    output logic [2:0]        bus_wday,
    output logic              month_end,
    output logic              year_end,
    output logic              load_err
);

    localparam logic [YEAR_W-1:0] Y_MIN    = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX    = YEAR_W'(YEAR_MAX);
    localparam logic [2:0]        WDAY_RST = 3'(WDAY_INIT);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic div100;
        logic div400;
        div100 = ((y % YEAR_W'(100)) == '0);
        div400 = ((y % YEAR_W'(400)) == '0);
        return (y[1:0] == 2'b00) && (!div100 || div400);
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        logic [4:0] len;
        case (m)
            4'd2:                      len = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
            default:                   len = 5'd31;
        endcase
        return len;
    endfunction

    logic [4:0]        day_q, day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic [2:0]        wday_q, wday_d;
    logic              month_end_q, month_end_d;
    logic              year_end_q, year_end_d;
    logic              load_err_q, load_err_d;

    logic [4:0] cur_len;
    logic [4:0] ld_len;
    logic       ld_valid;

    always_comb begin
        cur_len  = month_len(month_q, is_leap(year_q));
        ld_len   = month_len(ld_month, is_leap(ld_year));
        ld_valid = (ld_month >= 4'd1) && (ld_month <= 4'd12)
                && (ld_day != 5'd0) && (ld_day <= ld_len)
                && (ld_year >= Y_MIN) && (ld_year <= Y_MAX)
                && (ld_wday <= 3'd6);
    end

    // Load wins over tick; an invalid load still swallows a coincident tick.
    always_comb begin
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        wday_d      = wday_q;
        month_end_d = 1'b0;
        year_end_d  = 1'b0;
        load_err_d  = 1'b0;
        if (load) begin
            if (ld_valid) begin
                day_d   = ld_day;
                month_d = ld_month;
                year_d  = ld_year;
                wday_d  = ld_wday;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (day_tick) begin
            wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
            if (day_q < cur_len) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d       = 5'd1;
                month_end_d = 1'b1;
                if (month_q == 4'd12) begin
                    month_d    = 4'd1;
                    year_end_d = 1'b1;
                    year_d     = (year_q == Y_MAX) ? Y_MIN : year_q + YEAR_W'(1);
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= Y_MIN;
            wday_q      <= WDAY_RST;
            month_end_q <= 1'b0;
            year_end_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            wday_q      <= wday_d;
            month_end_q <= month_end_d;
            year_end_q  <= year_end_d;
            load_err_q  <= load_err_d;
        end
    end

    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign wday      = wday_q;
    assign month_end = month_end_q;
    assign year_end  = year_end_q;
    assign load_err  = load_err_q;

    assign bus_day   = {5{rd_en}} & day_q;
    assign bus_month = {4{rd_en}} & month_q;
    assign bus_year  = {YEAR_W{rd_en}} & year_q;
    assign bus_wday  = {3{rd_en}} & wday_q;

endmodule

// File: tb/tb_date_keeper.sv
// Bench for date_keeper: two instances (YEAR_MAX 2099 and 2199) share stimulus
// and are checked every cycle against a calendar model, plus literal pins.
module tb_date_keeper;

    localparam int YW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          day_tick = 1'b0;
    logic          load = 1'b0;
    logic [4:0]    ld_day = '0;
    logic [3:0]    ld_month = '0;
    logic [YW-1:0] ld_year = '0;
    logic [2:0]    ld_wday = '0;
    logic          rd_en = 1'b0;

    logic [4:0]    a_day, b_day, a_bday, b_bday;
    logic [3:0]    a_month, b_month, a_bmonth, b_bmonth;
    logic [YW-1:0] a_year, b_year, a_byear, b_byear;
    logic [2:0]    a_wday, b_wday, a_bwday, b_bwday;
    logic          a_me, a_ye, a_le, b_me, b_ye, b_le;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    date_keeper #(.YEAR_W(YW), .YEAR_MIN(2000), .YEAR_MAX(2099), .WDAY_INIT(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .ld_wday(ld_wday),
        .rd_en(rd_en),
        .day(a_day), .month(a_month), .year(a_year), .wday(a_wday),
        .bus_day(a_bday), .bus_month(a_bmonth), .bus_year(a_byear), .bus_wday(a_bwday),
        .month_end(a_me), .year_end(a_ye), .load_err(a_le)
    );

    date_keeper #(.YEAR_W(YW), .YEAR_MIN(2000), .YEAR_MAX(2199), .WDAY_INIT(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .ld_wday(ld_wday),
        .rd_en(rd_en),
        .day(b_day), .month(b_month), .year(b_year), .wday(b_wday),
        .bus_day(b_bday), .bus_month(b_bmonth), .bus_year(b_byear), .bus_wday(b_bwday),
        .month_end(b_me), .year_end(b_ye), .load_err(b_le)
    );

    // ---------------- calendar model ----------------
    typedef struct {
        int day;
        int month;
        int year;
        int wday;
        int me;
        int ye;
        int le;
    } date_t;

    function automatic int days_in(input int m, input int y);
        bit leap;
        leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
        case (m)
            2:           return leap ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic date_t reset_date();
        date_t r;
        r.day = 1; r.month = 1; r.year = 2000; r.wday = 6;
        r.me = 0; r.ye = 0; r.le = 0;
        return r;
    endfunction

    function automatic date_t next_date(input date_t s, input int ymax, input bit ld,
                                        input bit tk, input int d, input int m,
                                        input int y, input int w);
        date_t n;
        n = s;
        n.me = 0; n.ye = 0; n.le = 0;
        if (ld) begin
            if (m >= 1 && m <= 12 && d >= 1 && d <= days_in(m, y) &&
                y >= 2000 && y <= ymax && w <= 6) begin
                n.day = d; n.month = m; n.year = y; n.wday = w;
            end else begin
                n.le = 1;
            end
        end else if (tk) begin
            n.wday = (s.wday + 1) % 7;
            if (s.day < days_in(s.month, s.year)) begin
                n.day = s.day + 1;
            end else begin
                n.day = 1;
                n.me  = 1;
                if (s.month == 12) begin
                    n.month = 1;
                    n.ye    = 1;
                    n.year  = (s.year == ymax) ? 2000 : s.year + 1;
                end else begin
                    n.month = s.month + 1;
                end
            end
        end
        return n;
    endfunction

    date_t ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= reset_date();
            mb <= reset_date();
        end else begin
            ma <= next_date(ma, 2099, load, day_tick, int'(ld_day), int'(ld_month),
                            int'(ld_year), int'(ld_wday));
            mb <= next_date(mb, 2199, load, day_tick, int'(ld_day), int'(ld_month),
                            int'(ld_year), int'(ld_wday));
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input date_t m,
                           input int day, input int month, input int year, input int wday,
                           input int me, input int ye, input int le,
                           input int bday, input int bmonth, input int byear, input int bwday);
        check({tag, "_day"}, day, m.day);
        check({tag, "_month"}, month, m.month);
        check({tag, "_year"}, year, m.year);
        check({tag, "_wday"}, wday, m.wday);
        check({tag, "_month_end"}, me, m.me);
        check({tag, "_year_end"}, ye, m.ye);
        check({tag, "_load_err"}, le, m.le);
        check({tag, "_bus_day"}, bday, rd_en ? m.day : 0);
        check({tag, "_bus_month"}, bmonth, rd_en ? m.month : 0);
        check({tag, "_bus_year"}, byear, rd_en ? m.year : 0);
        check({tag, "_bus_wday"}, bwday, rd_en ? m.wday : 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_all("a", ma, a_day, a_month, a_year, a_wday, a_me, a_ye, a_le,
                    a_bday, a_bmonth, a_byear, a_bwday);
            cmp_all("b", mb, b_day, b_month, b_year, b_wday, b_me, b_ye, b_le,
                    b_bday, b_bmonth, b_byear, b_bwday);
        end
    end

    // ---------------- drivers ----------------
    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic set_load(input int d, input int m, input int y, input int w);
        load     = 1'b1;
        ld_day   = 5'(d);
        ld_month = 4'(m);
        ld_year  = YW'(y);
        ld_wday  = 3'(w);
    endtask

    initial begin
        // Reset state, read bus disabled then enabled
        repeat (2) @(posedge clk);
        #2;
        check("rst_day", a_day, 1);
        check("rst_month", a_month, 1);
        check("rst_year", a_year, 2000);
        check("rst_wday", a_wday, 6);
        check("rst_flags", {a_me, a_ye, a_le}, 0);
        check("rst_bus_off", {a_bday, a_bmonth, a_byear, a_bwday}, 0);
        rd_en = 1'b1;
        #1;
        check("rst_bus_day", a_bday, 1);
        check("rst_bus_month", a_bmonth, 1);
        check("rst_bus_year", a_byear, 2000);
        check("rst_bus_wday", a_bwday, 6);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Leap-day walk: 2024-02-28 -> 29 -> 03-01, load on first edge after reset
        set_load(28, 2, 2024, 3);
        next_edge();
        load = 1'b0;
        check("ld_2024_day", a_day, 28);
        check("ld_2024_year", a_year, 2024);
        check("ld_2024_err", a_le, 0);
        day_tick = 1'b1;
        next_edge();
        check("feb29_day", a_day, 29);
        check("feb29_wday", a_wday, 4);
        check("model_feb29", ma.day, 29);
        check("feb29_me", a_me, 0);
        next_edge();
        day_tick = 1'b0;
        check("mar1_day", a_day, 1);
        check("mar1_month", a_month, 3);
        check("mar1_wday", a_wday, 5);
        check("mar1_me", a_me, 1);
        check("model_mar1", ma.month, 3);
        next_edge();
        check("mar1_me_clear", a_me, 0);

        // 2100 is not leap (YEAR_MAX=2199 instance); 2000 is leap
        set_load(28, 2, 2100, 1);
        next_edge();
        load = 1'b0;
        check("b_ld_2100_year", b_year, 2100);
        check("a_ld_2100_err", a_le, 1);
        check("a_ld_2100_kept", a_year, 2024);
        day_tick = 1'b1;
        next_edge();
        day_tick = 1'b0;
        check("b_2100_mar_day", b_day, 1);
        check("b_2100_mar_month", b_month, 3);
        check("model_2100", mb.month, 3);
        set_load(29, 2, 2000, 2);
        next_edge();
        load = 1'b0;
        check("ld_2000_feb29_err", a_le, 0);
        check("ld_2000_feb29_day", a_day, 29);
        check("b_ld_2000_feb29_err", b_le, 0);

        // Year wrap 2099-12-31 -> 2000-01-01
        set_load(31, 12, 2099, 4);
        next_edge();
        load = 1'b0;
        day_tick = 1'b1;
        next_edge();
        day_tick = 1'b0;
        check("wrap_day", a_day, 1);
        check("wrap_month", a_month, 1);
        check("wrap_year", a_year, 2000);
        check("wrap_wday", a_wday, 5);
        check("wrap_me", a_me, 1);
        check("wrap_ye", a_ye, 1);
        check("b_nowrap_year", b_year, 2100);
        check("model_wrap", ma.year, 2000);
        next_edge();
        check("wrap_ye_clear", a_ye, 0);

        // Invalid load with tick: tick discarded, error pulse
        set_load(29, 2, 2023, 0);
        day_tick = 1'b1;
        next_edge();
        load = 1'b0;
        day_tick = 1'b0;
        check("bad_ld_err", a_le, 1);
        check("bad_ld_day", a_day, 1);
        check("bad_ld_year", a_year, 2000);
        check("bad_ld_wday", a_wday, 5);
        next_edge();
        check("bad_ld_err_clear", a_le, 0);

        // Asynchronous reset between edges, with a tick in flight
        set_load(15, 7, 2050, 5);
        next_edge();
        load = 1'b0;
        check("ld_2050_day", a_day, 15);
        #1;
        day_tick = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_day", a_day, 1);
        check("async_month", a_month, 1);
        check("async_year", a_year, 2000);
        check("async_wday", a_wday, 6);
        check("async_flags", {a_me, a_ye, a_le}, 0);
        next_edge();
        rst_n = 1'b1;
        day_tick = 1'b0;
        next_edge();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 399) != 0);
            load     = ($urandom_range(0, 7) == 0);
            day_tick = ($urandom_range(0, 3) != 0);
            rd_en    = $urandom_range(0, 1) != 0;
            ld_day   = 5'($urandom_range(0, 31));
            ld_month = 4'($urandom_range(0, 13));
            ld_year  = YW'($urandom_range(1998, 2201));
            ld_wday  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                ld_month = 4'd12;
                ld_day   = 5'd31;
                ld_year  = YW'(($urandom_range(0, 1) != 0) ? 2099 : 2199);
            end
            next_edge();
        end
        rst_n = 1'b1;
        load = 1'b0;
        day_tick = 1'b0;
        next_edge();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
